mux_4: RTL and testbench



---
 rtl/mux_4.sv | 59 +++++
 tb/tb_mux_4.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mux_4.sv
// Four-way WIDTH-bit selector with a zero-latency combinational output plus a
// registered side channel: registered result, registered select, select-change counter.
module mux_4 #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] mux_out,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] mux_out_q,
    output logic [1:0]       sel_q,
    output logic [CNT_W-1:0] sel_chg_cnt
);

    logic [WIDTH-1:0] mux_out_d;
    logic [1:0]       sel_d;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        // NOTE: defaults first keep this latch-free; a sel holding X/Z matches no
        // item and falls to the default, so it reads as code 00 with zero data.
        mux_out = '0;
        sel_d   = 2'b00;
        case (sel)
            2'b00: begin mux_out = in0; sel_d = 2'b00; end
            2'b01: begin mux_out = in1; sel_d = 2'b01; end
            2'b10: begin mux_out = in2; sel_d = 2'b10; end
            2'b11: begin mux_out = in3; sel_d = 2'b11; end
            default: begin mux_out = '0; sel_d = 2'b00; end
        endcase

        mux_out_d = mux_out;
        cnt_d     = cnt_q;
        if ((sel_d != sel_q) && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            mux_out_q <= '0;
            sel_q     <= 2'b00;
            cnt_q     <= '0;
        end else begin
            mux_out_q <= mux_out_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sel_chg_cnt = cnt_q;

endmodule

// File: tb/tb_mux_4.sv
// Self-checking bench for mux_4: directed spec scenarios, exhaustive select sweep and
// random traffic, all compared against a behavioural model built from the block's rules.
module tb_mux_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in0, in1, in2, in3;
    logic [1:0] sel;

    logic [1:0] mux_out, mux_out_q, sel_q;
    logic [7:0] cnt8;
    logic [1:0] mux_out_s, mux_out_q_s, sel_q_s;
    logic [1:0] cnt2;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [1:0] m_mux_q;
    logic [1:0] m_sel_q;
    int         m_cnt;
    bit         checks_on = 1'b0;

    always #5 clk = ~clk;

    mux_4 #(.WIDTH(2), .CNT_W(8)) u_dut (
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .sel(sel),
        .mux_out(mux_out), .clk(clk), .rst(rst),
        .mux_out_q(mux_out_q), .sel_q(sel_q), .sel_chg_cnt(cnt8)
    );

    mux_4 #(.WIDTH(2), .CNT_W(2)) u_sat (
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .sel(sel),
        .mux_out(mux_out_s), .clk(clk), .rst(rst),
        .mux_out_q(mux_out_q_s), .sel_q(sel_q_s), .sel_chg_cnt(cnt2)
    );

    function automatic logic [1:0] exp_comb();
        logic [1:0] din [4];
        din[0] = in0; din[1] = in1; din[2] = in2; din[3] = in3;
        if ($isunknown(sel)) return 2'b00;
        return din[sel];
    endfunction

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mux_q   = 2'b00;
            m_sel_q   = 2'b00;
            m_cnt     = 0;
            checks_on = 1'b1;
        end else begin
            logic [1:0] ns;
            ns = $isunknown(sel) ? 2'b00 : sel;
            if (ns != m_sel_q) m_cnt++;
            m_mux_q = exp_comb();
            m_sel_q = ns;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
            $error("check %s", tag);
        end
    endtask

    task automatic check_regs();
        check("mux_out_q", 32'(mux_out_q), 32'(m_mux_q));
        check("sel_q", 32'(sel_q), 32'(m_sel_q));
        check("cnt8", 32'(cnt8), sat(m_cnt, 255));
        check("sel_q_s", 32'(sel_q_s), 32'(m_sel_q));
        check("cnt2", 32'(cnt2), sat(m_cnt, 3));
    endtask

    // One cycle: verify registered state from the previous edge, apply new inputs,
    // then verify the combinational output for them.
    task automatic drive(input logic r, input logic [1:0] s,
                         input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] c, input logic [1:0] d);
        @(negedge clk);
        if (checks_on) check_regs();
        rst = r; sel = s; in0 = a; in1 = b; in2 = c; in3 = d;
        #1;
        check("mux_out", 32'(mux_out), 32'(exp_comb()));
        check("mux_out_s", 32'(mux_out_s), 32'(exp_comb()));
    endtask

    task automatic settle();
        @(negedge clk);
        check_regs();
    endtask

    initial begin
        rst = 1'b1; sel = 2'b00; in0 = '0; in1 = '0; in2 = '0; in3 = '0;

        // Reset holds registers while the data path keeps following its inputs.
        drive(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b10);
        drive(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b10);
        settle();
        check("rst_mux_out", 32'(mux_out), 32'h2);
        check("rst_mux_out_q", 32'(mux_out_q), 32'h0);
        check("rst_sel_q", 32'(sel_q), 32'h0);
        check("rst_cnt", 32'(cnt8), 32'h0);

        // First transfer after reset.
        drive(1'b0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00);
        settle();
        check("first_mux_out_q", 32'(mux_out_q), 32'h3);
        check("first_sel_q", 32'(sel_q), 32'h1);

        // Change counter: 01,01,10,11,11 after reset.
        drive(1'b1, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00);
        drive(1'b0, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00);
        drive(1'b0, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00);
        drive(1'b0, 2'b10, 2'b01, 2'b10, 2'b11, 2'b00);
        drive(1'b0, 2'b11, 2'b01, 2'b10, 2'b11, 2'b00);
        drive(1'b0, 2'b11, 2'b01, 2'b10, 2'b11, 2'b00);
        settle();
        check("chg_cnt_seq", 32'(cnt8), 32'd3);

        // Saturation of the 2-bit counter, then reset coinciding with a sel change.
        drive(1'b1, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11);
        for (int i = 0; i < 6; i++)
            drive(1'b0, (i % 2 == 0) ? 2'b01 : 2'b00, 2'b00, 2'b01, 2'b10, 2'b11);
        settle();
        check("sat_cnt2", 32'(cnt2), 32'd3);
        check("sat_cnt8", 32'(cnt8), 32'd6);
        drive(1'b1, 2'b01, 2'b00, 2'b01, 2'b10, 2'b11);
        settle();
        check("sat_rst_cnt2", 32'(cnt2), 32'd0);
        check("sat_rst_cnt8", 32'(cnt8), 32'd0);

        // Invalid select code.
        drive(1'b0, 2'bx1, 2'b01, 2'b10, 2'b11, 2'b11);
        if ($isunknown(sel)) check("sel_x_mux_out", 32'(mux_out), 32'h0);
        settle();
        if ($isunknown(sel)) check("sel_x_sel_q", 32'(sel_q), 32'h0);

        // Exhaustive sweep of sel and all four inputs.
        for (int v = 0; v < 1024; v++) begin
            logic [9:0] vec;
            vec = 10'(v);
            drive(1'b0, vec[9:8], vec[7:6], vec[5:4], vec[3:2], vec[1:0]);
        end

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++)
            drive(($urandom_range(0, 15) == 0), 2'($urandom), 2'($urandom),
                  2'($urandom), 2'($urandom), 2'($urandom));
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
